// File: rtl/router_pkg.sv
// Shared MinBD router definitions: flit field positions, direction codes, channel indices.
// Also holds the XY route-direction helper used by the injection controller.
package router_pkg;

    localparam int unsigned FLIT_W = 11;

    localparam int unsigned TAG_HI = 10;
    localparam int unsigned TAG_LO = 9;
    localparam int unsigned DIR_HI = 8;
    localparam int unsigned DIR_LO = 6;
    localparam int unsigned ROW_HI = 5;
    localparam int unsigned ROW_LO = 3;
    localparam int unsigned COL_HI = 2;
    localparam int unsigned COL_LO = 0;

    localparam int unsigned CH_N   = 0;
    localparam int unsigned CH_S   = 1;
    localparam int unsigned CH_E   = 2;
    localparam int unsigned CH_W   = 3;
    localparam int unsigned NUM_CH = 4;

    typedef enum logic [2:0] {
        DIR_E     = 3'b000,
        DIR_W     = 3'b001,
        DIR_N     = 3'b010,
        DIR_S     = 3'b011,
        DIR_LOCAL = 3'b100
    } dir_e;

    // Column is resolved first, then row (dimension-ordered routing).
    function automatic dir_e route_dir(input logic [2:0] row, input logic [2:0] col,
                                       input logic [2:0] my_row, input logic [2:0] my_col);
        if (col > my_col)      return DIR_E;
        else if (col < my_col) return DIR_W;
        else if (row > my_row) return DIR_N;
        else if (row < my_row) return DIR_S;
        else                   return DIR_LOCAL;
    endfunction

endpackage

// File: rtl/inject_scheduler_if.sv
// PE-side and channel-side signals of the injection controller, bundled as one interface.
interface inject_scheduler_if
    import router_pkg::*;
#(
    parameter int unsigned DEPTH = 4
);

    logic [FLIT_W-1:0]       pe_flit;
    logic                    pe_vld;
    logic                    pe_rdy;
    logic [NUM_CH-1:0]       ch_vld;
    logic [FLIT_W-1:0]       inj_flit;
    logic [NUM_CH-1:0]       inj_sel;
    logic [FLIT_W-1:0]       loc_flit;
    logic                    loc_vld;
    logic                    starve;
    logic [$clog2(DEPTH):0]  fifo_cnt;

    modport master (
        output pe_flit, pe_vld, ch_vld,
        input  pe_rdy, inj_flit, inj_sel, loc_flit, loc_vld, starve, fifo_cnt
    );

    modport slave (
        input  pe_flit, pe_vld, ch_vld,
        output pe_rdy, inj_flit, inj_sel, loc_flit, loc_vld, starve, fifo_cnt
    );

endinterface

// File: rtl/inj_fifo.sv
// Injection FIFO: synchronous write, asynchronous head read, occupancy count.
module inj_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] cnt
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]     cnt_q;
    logic              push, pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (PtrW+1)'(DEPTH));
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr_q];
    assign cnt     = cnt_q;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/inject_scheduler.sv
// Local-injection controller for one MinBD node: buffers PE flits, routes the head flit,
// grants the first free outgoing slot and flags starvation.
module inject_scheduler
    import router_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter logic [2:0]  MY_ROW       = 3'd4,
    parameter logic [2:0]  MY_COL       = 3'd4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    inject_scheduler_if.slave  bus
);

    localparam logic [7:0] Limit = 8'(STARVE_LIMIT);

    logic [FLIT_W-1:0]      head;
    logic                   empty, full;
    logic [$clog2(DEPTH):0] cnt;
    dir_e                   dir;
    logic                   is_local;
    logic                   blocked;
    logic                   pop;
    logic [NUM_CH-1:0]      free_sel;
    logic [7:0]             wait_q, wait_d;
    logic                   starve_q;

    inj_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FLIT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.pe_vld),
        .wr_data (bus.pe_flit),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (empty),
        .full    (full),
        .cnt     (cnt)
    );

    assign dir      = route_dir(head[ROW_HI:ROW_LO], head[COL_HI:COL_LO], MY_ROW, MY_COL);
    assign is_local = !empty && (dir == DIR_LOCAL);
    assign blocked  = !empty && (dir != DIR_LOCAL) && (&bus.ch_vld);

    // Lowest-index free slot wins (N > S > E > W).
    always_comb begin
        free_sel = '0;
        casez (bus.ch_vld)
            4'b???0: free_sel[CH_N] = 1'b1;
            4'b??01: free_sel[CH_S] = 1'b1;
            4'b?011: free_sel[CH_E] = 1'b1;
            4'b0111: free_sel[CH_W] = 1'b1;
            default: free_sel = '0;
        endcase
    end

    always_comb begin
        bus.inj_flit = '0;
        if (!empty) bus.inj_flit = {head[TAG_HI:TAG_LO], dir, head[ROW_HI:COL_LO]};
        bus.inj_sel  = (!empty && !is_local) ? free_sel : '0;
        bus.loc_vld  = is_local;
        bus.loc_flit = is_local ? bus.inj_flit : '0;
    end

    assign pop          = (|bus.inj_sel) || is_local;
    assign bus.pe_rdy   = !full;
    assign bus.fifo_cnt = cnt;
    assign bus.starve   = starve_q;

    always_comb begin
        wait_d = wait_q;
        if (pop || empty)                wait_d = '0;
        else if (blocked && wait_q < Limit) wait_d = wait_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q   <= '0;
            starve_q <= 1'b0;
        end else begin
            wait_q   <= wait_d;
            starve_q <= (wait_d == Limit);
        end
    end

endmodule

// File: tb/tb_inject_scheduler.sv
// Directed bench for inject_scheduler with a queue-based reference model checked every cycle.
module tb_inject_scheduler;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 8;

    logic clk;
    logic rst_n;

    inject_scheduler_if #(.DEPTH(DEPTH)) bus ();

    inject_scheduler #(
        .DEPTH        (DEPTH),
        .MY_ROW       (3'd4),
        .MY_COL       (3'd4),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: flit queue plus count of consecutive blocked edges.
    logic [10:0] mq[$];
    int          mwait = 0;

    function automatic logic [2:0] model_dir(input logic [10:0] f);
        int r, c;
        r = int'(f[5:3]);
        c = int'(f[2:0]);
        if (c > 4) return 3'b000;
        if (c < 4) return 3'b001;
        if (r > 4) return 3'b010;
        if (r < 4) return 3'b011;
        return 3'b100;
    endfunction

    function automatic logic [3:0] model_sel(input logic [3:0] ch);
        for (int i = 0; i < 4; i++) begin
            if (ch[i] == 1'b0) return 4'(1 << i);
        end
        return 4'b0000;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mwait = 0;
        end else begin
            logic        was_full, do_pop, local_hd;
            logic [10:0] incoming;
            incoming = bus.pe_flit;
            was_full = (mq.size() == DEPTH);
            do_pop   = 1'b0;
            if (mq.size() == 0) begin
                mwait = 0;
            end else begin
                local_hd = (model_dir(mq[0]) == 3'b100);
                do_pop   = local_hd || (bus.ch_vld != 4'b1111);
                if (do_pop) mwait = 0;
                else if (mwait < LIMIT) mwait++;
            end
            if (do_pop) void'(mq.pop_front());
            if (bus.pe_vld && !was_full) mq.push_back(incoming);
        end
    end

    always @(negedge clk) begin
        logic [10:0] e_flit, e_loc;
        logic [3:0]  e_sel;
        logic        e_lv;
        e_flit = '0;
        e_loc  = '0;
        e_sel  = '0;
        e_lv   = 1'b0;
        if (mq.size() != 0) begin
            e_flit = {mq[0][10:9], model_dir(mq[0]), mq[0][5:0]};
            if (model_dir(mq[0]) == 3'b100) begin
                e_lv  = 1'b1;
                e_loc = e_flit;
            end else begin
                e_sel = model_sel(bus.ch_vld);
            end
        end
        check("inj_flit", 32'(bus.inj_flit), 32'(e_flit));
        check("inj_sel",  32'(bus.inj_sel),  32'(e_sel));
        check("loc_vld",  32'(bus.loc_vld),  32'(e_lv));
        check("loc_flit", 32'(bus.loc_flit), 32'(e_loc));
        check("fifo_cnt", 32'(bus.fifo_cnt), 32'(mq.size()));
        check("pe_rdy",   32'(bus.pe_rdy),   32'(mq.size() != DEPTH));
        check("starve",   32'(bus.starve),   32'(mwait == LIMIT));
    end

    initial begin
        logic [2:0] d;
        logic [1:0] t;
        rst_n       = 1'b0;
        bus.pe_flit = '0;
        bus.pe_vld  = 1'b0;
        bus.ch_vld  = 4'b0000;
        #12;
        check("rst_cnt",    32'(bus.fifo_cnt), 32'd0);
        check("rst_rdy",    32'(bus.pe_rdy),   32'd1);
        check("rst_starve", 32'(bus.starve),   32'd0);
        check("rst_sel",    32'(bus.inj_sel),  32'd0);
        check("rst_flit",   32'(bus.inj_flit), 32'd0);
        rst_n = 1'b1;

        // Eastbound flit, all slots free.
        bus.pe_flit = 11'h00E;
        bus.pe_vld  = 1'b1;
        tick();
        bus.pe_vld = 1'b0;
        check("t1_flit", 32'(bus.inj_flit), 32'h00E);
        check("t1_sel",  32'(bus.inj_sel),  32'b0001);
        tick();
        check("t1_empty", 32'(bus.fifo_cnt), 32'd0);

        // Self-addressed flit loops back.
        bus.ch_vld  = 4'b1011;
        bus.pe_flit = 11'h224;
        bus.pe_vld  = 1'b1;
        tick();
        bus.pe_vld = 1'b0;
        check("t2_locv", 32'(bus.loc_vld),  32'd1);
        check("t2_sel",  32'(bus.inj_sel),  32'd0);
        check("t2_locf", 32'(bus.loc_flit), 32'h324);
        tick();
        check("t2_empty", 32'(bus.fifo_cnt), 32'd0);

        // Northbound flit, only W free.
        bus.ch_vld  = 4'b0111;
        bus.pe_flit = 11'h034;
        bus.pe_vld  = 1'b1;
        tick();
        bus.pe_vld = 1'b0;
        d = bus.inj_flit[8:6];
        check("t3_sel", 32'(bus.inj_sel), 32'b1000);
        check("t3_dir", 32'(d),           32'b010);
        tick();

        // Fill to full with all slots busy; fifth push is refused.
        bus.ch_vld = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            t           = 2'(i);
            bus.pe_flit = {t, 9'h00E};
            bus.pe_vld  = 1'b1;
            tick();
        end
        bus.pe_vld = 1'b0;
        check("t4_full_cnt", 32'(bus.fifo_cnt), 32'd4);
        check("t4_full_rdy", 32'(bus.pe_rdy),   32'd0);
        bus.ch_vld = 4'b1110;
        tick();
        tick();
        check("t4_cnt2", 32'(bus.fifo_cnt), 32'd2);
        bus.pe_flit = 11'h60E;
        bus.pe_vld  = 1'b1;
        tick();
        bus.pe_vld = 1'b0;
        check("t4_pushpop", 32'(bus.fifo_cnt), 32'd2);
        tick();
        tick();
        check("t4_drained", 32'(bus.fifo_cnt), 32'd0);

        // Starvation: eight blocked edges raise starve; release clears it on the pop edge.
        bus.ch_vld  = 4'b1111;
        bus.pe_flit = 11'h00E;
        bus.pe_vld  = 1'b1;
        tick();
        bus.pe_vld = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("t5_pre", 32'(bus.starve), 32'd0);
        tick();
        check("t5_rise", 32'(bus.starve), 32'd1);
        bus.ch_vld = 4'b1110;
        #1;
        check("t5_sel", 32'(bus.inj_sel), 32'b0001);
        tick();
        check("t5_fall", 32'(bus.starve), 32'd0);

        // Reset mid-burst drops queued flits.
        bus.ch_vld = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            bus.pe_flit = 11'h031;
            bus.pe_vld  = 1'b1;
            tick();
        end
        bus.pe_vld = 1'b0;
        check("t6_cnt3", 32'(bus.fifo_cnt), 32'd3);
        #2;
        rst_n      = 1'b0;
        bus.ch_vld = 4'b0000;
        #1;
        check("t6_cnt",    32'(bus.fifo_cnt), 32'd0);
        check("t6_starve", 32'(bus.starve),   32'd0);
        check("t6_sel",    32'(bus.inj_sel),  32'd0);
        check("t6_locv",   32'(bus.loc_vld),  32'd0);
        tick();
        rst_n       = 1'b1;
        bus.pe_flit = 11'h00E;
        bus.pe_vld  = 1'b1;
        tick();
        bus.pe_vld = 1'b0;
        check("t6_sel_after",  32'(bus.inj_sel),  32'b0001);
        check("t6_flit_after", 32'(bus.inj_flit), 32'h00E);
        tick();
        check("t6_empty", 32'(bus.fifo_cnt), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
